mul_err_accum: RTL and testbench

// Downstream error-characterisation stage for the approximate 8x8 Dadda multipliers.

---
 rtl/mul_err_accum_if.sv | 33 +++
 rtl/mul_err_accum.sv | 96 +++++++++
 tb/tb_mul_err_accum.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_err_accum_if.sv
// Handshake bundle between the error-characterisation stage and its harness:
// sample stream in, window results out, plus start/busy control.
interface mul_err_accum_if #(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 256,
    parameter int SUM_W       = 32
);
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);

    logic                 start;
    logic                 busy;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     op_a;
    logic [WIDTH-1:0]     op_b;
    logic [2*WIDTH-1:0]   approx_p;
    logic                 res_valid;
    logic                 res_ready;
    logic [SUM_W-1:0]     sum_ed;
    logic                 sum_sat;
    logic [CNT_W-1:0]     err_count;
    logic [2*WIDTH-1:0]   max_ed;

    modport master (
        output start, in_valid, op_a, op_b, approx_p, res_ready,
        input  busy, in_ready, res_valid, sum_ed, sum_sat, err_count, max_ed
    );

    modport slave (
        input  start, in_valid, op_a, op_b, approx_p, res_ready,
        output busy, in_ready, res_valid, sum_ed, sum_sat, err_count, max_ed
    );
endinterface

// File: rtl/mul_err_accum.sv
// Error-distance accumulator for approximate multipliers: per window of
// NUM_SAMPLES it reports saturating sum of |exact-approx|, non-zero count and max.
module mul_err_accum #(
    parameter int WIDTH       = 8,
    parameter int NUM_SAMPLES = 256,
    parameter int SUM_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    mul_err_accum_if.slave   bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    // Adder wide enough for either operand plus a carry, so a narrow SUM_W still sees every overflow.
    localparam int AW    = ((SUM_W > PW) ? SUM_W : PW) + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, REPORT} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   accepted;
    logic               hs, last_hs, clr;
    logic [PW-1:0]      exact, ed_d, ed_q;
    logic               ed_vld;
    logic [AW-1:0]      sum_ext;
    logic [SUM_W-1:0]   sum_q;
    logic               sat_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PW-1:0]      max_q;

    assign bus.in_ready  = (state == ACCUM) && (accepted < CNT_W'(NUM_SAMPLES));
    assign bus.res_valid = (state == REPORT);
    assign bus.busy      = (state != IDLE);
    assign bus.sum_ed    = sum_q;
    assign bus.sum_sat   = sat_q;
    assign bus.err_count = cnt_q;
    assign bus.max_ed    = max_q;

    assign hs      = bus.in_valid && bus.in_ready;
    assign last_hs = hs && (accepted == CNT_W'(NUM_SAMPLES - 1));
    assign clr     = (state == IDLE) && bus.start;

    assign exact   = PW'(bus.op_a) * PW'(bus.op_b);
    assign ed_d    = (exact >= bus.approx_p) ? exact - bus.approx_p : bus.approx_p - exact;
    assign sum_ext = AW'(sum_q) + AW'(ed_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // DRAIN waits only for the stage-1 register: the accumulate it feeds lands on the same edge it empties.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start)     state_nx = ACCUM;
            ACCUM:   if (last_hs)       state_nx = DRAIN;
            DRAIN:   if (!ed_vld)       state_nx = REPORT;
            REPORT:  if (bus.res_ready) state_nx = IDLE;
            default:                    state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted <= '0;
            ed_vld   <= 1'b0;
            ed_q     <= '0;
            sum_q    <= '0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
            max_q    <= '0;
        end else begin
            ed_vld <= hs;
            if (hs) ed_q <= ed_d;
            if (clr) begin
                accepted <= '0;
                sum_q    <= '0;
                sat_q    <= 1'b0;
                cnt_q    <= '0;
                max_q    <= '0;
            end else begin
                if (hs) accepted <= accepted + CNT_W'(1);
                if (ed_vld) begin
                    if (|sum_ext[AW-1:SUM_W]) begin
                        sum_q <= '1;
                        sat_q <= 1'b1;
                    end else begin
                        sum_q <= sum_ext[SUM_W-1:0];
                    end
                    if (ed_q != '0)   cnt_q <= cnt_q + CNT_W'(1);
                    if (ed_q > max_q) max_q <= ed_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mul_err_accum.sv
// Self-checking bench: table windows, hand sequences for the control corner
// cases, and random windows against an arithmetic reference.
module tb_mul_err_accum;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mul_err_accum_if #(.WIDTH(8), .NUM_SAMPLES(4), .SUM_W(32)) b4 ();
    mul_err_accum_if #(.WIDTH(8), .NUM_SAMPLES(2), .SUM_W(10)) b2 ();

    mul_err_accum #(.WIDTH(8), .NUM_SAMPLES(4), .SUM_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    mul_err_accum #(.WIDTH(8), .NUM_SAMPLES(2), .SUM_W(10)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    typedef struct {
        string             name;
        logic [3:0][7:0]   a;
        logic [3:0][7:0]   b;
        logic [3:0][15:0]  p;
        int                gap;
        int                rr;
        longint            sum;
        int                cnt;
        int                mx;
    } vec_t;

    vec_t tbl[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start4();
        b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        check("start_busy", b4.busy, 1);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int n = 0;
        b4.op_a = a; b4.op_b = b; b4.approx_p = p; b4.in_valid = 1'b1;
        @(negedge clk);
        while (!b4.in_ready && n < 20) begin @(negedge clk); n++; end
        check("send4_accepted", b4.in_ready, 1);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic send2(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p);
        int n = 0;
        b2.op_a = a; b2.op_b = b; b2.approx_p = p; b2.in_valid = 1'b1;
        @(negedge clk);
        while (!b2.in_ready && n < 20) begin @(negedge clk); n++; end
        check("send2_accepted", b2.in_ready, 1);
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    task automatic wait_rep4();
        int n = 0;
        while (!b4.res_valid && n < 20) begin @(posedge clk); #1; n++; end
        check("report_reached", b4.res_valid, 1);
    endtask

    task automatic chk4(input string name, input longint sum, input int sat, input int cnt, input int mx);
        check({name, "_sum"}, b4.sum_ed, sum);
        check({name, "_sat"}, b4.sum_sat, sat);
        check({name, "_cnt"}, b4.err_count, cnt);
        check({name, "_max"}, b4.max_ed, mx);
    endtask

    // Hold res_ready low for rr cycles (outputs must not move), then complete the handshake.
    task automatic release4(input string name, input int rr, input longint sum, input int cnt, input int mx);
        for (int c = 0; c < rr; c++) begin
            @(posedge clk); #1;
            check({name, "_hold_valid"}, b4.res_valid, 1);
            check({name, "_hold_sum"}, b4.sum_ed, sum);
            check({name, "_hold_max"}, b4.max_ed, mx);
        end
        b4.res_ready = 1'b1;
        @(posedge clk); #1;
        b4.res_ready = 1'b0;
        check({name, "_busy_after_ack"}, b4.busy, 0);
        check({name, "_valid_after_ack"}, b4.res_valid, 0);
        check({name, "_idle_cnt_kept"}, b4.err_count, cnt);
    endtask

    initial begin
        logic [3:0][7:0]  ra, rb;
        logic [3:0][15:0] rp;
        longint           m_sum, ex, ed;
        int               m_cnt, m_max;

        tbl[0] = '{"t1_exact", {8'd255, 8'd0, 8'd20, 8'd10}, {8'd255, 8'd9, 8'd7, 8'd3},
                   {16'd65025, 16'd0, 16'd140, 16'd30}, 0, 0, 0, 0, 0};
        tbl[1] = '{"t2_mixed", {8'd0, 8'd200, 8'd255, 8'd3}, {8'd0, 8'd100, 8'd255, 8'd5},
                   {16'd7, 16'd19000, 16'd65025, 16'd14}, 0, 1, 1008, 3, 1000};
        tbl[2] = '{"t4_gaps", {8'd0, 8'd200, 8'd255, 8'd3}, {8'd0, 8'd100, 8'd255, 8'd5},
                   {16'd7, 16'd19000, 16'd65025, 16'd14}, 2, 5, 1008, 3, 1000};
        tbl[3] = '{"extremes", {8'd16, 8'd0, 8'd1, 8'd255}, {8'd16, 8'd0, 8'd1, 8'd255},
                   {16'd256, 16'd65535, 16'd0, 16'd0}, 1, 2, 130561, 3, 65535};

        b4.start = 0; b4.in_valid = 0; b4.op_a = 0; b4.op_b = 0; b4.approx_p = 0; b4.res_ready = 0;
        b2.start = 0; b2.in_valid = 0; b2.op_a = 0; b2.op_b = 0; b2.approx_p = 0; b2.res_ready = 0;

        #3;
        chk4("reset", 0, 0, 0, 0);
        check("reset_busy", b4.busy, 0);
        check("reset_in_ready", b4.in_ready, 0);
        check("reset_res_valid", b4.res_valid, 0);
        check("reset2_res_valid", b2.res_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table windows; the 4th handshake edge is E, results valid only after E+2.
        for (int i = 0; i < 4; i++) begin
            start4();
            for (int k = 0; k < 4; k++) begin
                for (int g = 0; g < tbl[i].gap; g++) begin
                    b4.op_a = 8'($urandom); b4.approx_p = 16'($urandom);
                    @(posedge clk); #1;
                end
                send4(tbl[i].a[k], tbl[i].b[k], tbl[i].p[k]);
            end
            check({tbl[i].name, "_rv_E"}, b4.res_valid, 0);
            @(posedge clk); #1;
            check({tbl[i].name, "_rv_E1"}, b4.res_valid, 0);
            check({tbl[i].name, "_drain_in_ready"}, b4.in_ready, 0);
            @(posedge clk); #1;
            check({tbl[i].name, "_rv_E2"}, b4.res_valid, 1);
            chk4(tbl[i].name, tbl[i].sum, 0, tbl[i].cnt, tbl[i].mx);
            release4(tbl[i].name, tbl[i].rr, tbl[i].sum, tbl[i].cnt, tbl[i].mx);
        end

        // Stray start in ACCUM/REPORT, extra sample offered in DRAIN, start coinciding with the ack.
        start4();
        send4(8'd3, 8'd5, 16'd14);
        send4(8'd255, 8'd255, 16'd65025);
        b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        send4(8'd200, 8'd100, 16'd19000);
        send4(8'd0, 8'd0, 16'd7);
        b4.op_a = 8'd1; b4.op_b = 8'd1; b4.approx_p = 16'd500; b4.in_valid = 1'b1;
        @(negedge clk);
        check("t5_extra_in_ready", b4.in_ready, 0);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        wait_rep4();
        b4.start = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0;
        check("t5_start_in_report", b4.res_valid, 1);
        chk4("t5", 1008, 0, 3, 1000);
        b4.start = 1'b1; b4.res_ready = 1'b1;
        @(posedge clk); #1;
        b4.start = 1'b0; b4.res_ready = 1'b0;
        check("t5_ack_busy", b4.busy, 0);
        @(posedge clk); #1;
        check("t5_no_restart", b4.busy, 0);
        check("t5_idle_in_ready", b4.in_ready, 0);

        // Reset in the middle of a window with a sample still in flight.
        start4();
        send4(8'd3, 8'd5, 16'd14);
        send4(8'd200, 8'd100, 16'd19000);
        rst = 1'b1;
        #1;
        chk4("t6_rst", 0, 0, 0, 0);
        check("t6_rst_busy", b4.busy, 0);
        check("t6_rst_in_ready", b4.in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_post_rst_max", b4.max_ed, 0);
        start4();
        for (int k = 0; k < 4; k++) send4(tbl[1].a[k], tbl[1].b[k], tbl[1].p[k]);
        wait_rep4();
        chk4("t6_after", 1008, 0, 3, 1000);
        release4("t6_after", 0, 1008, 3, 1000);

        // Narrow sum: two EDs of 1000 overflow 10 bits; the next start clears the sticky flag.
        b2.start = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        send2(8'd200, 8'd100, 16'd19000);
        send2(8'd200, 8'd100, 16'd19000);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t3_valid", b2.res_valid, 1);
        check("t3_sum", b2.sum_ed, 1023);
        check("t3_sat", b2.sum_sat, 1);
        check("t3_cnt", b2.err_count, 2);
        check("t3_max", b2.max_ed, 1000);
        b2.res_ready = 1'b1;
        @(posedge clk); #1;
        b2.res_ready = 1'b0;
        b2.start = 1'b1;
        @(posedge clk); #1;
        b2.start = 1'b0;
        check("t3_restart_sat_cleared", b2.sum_sat, 0);
        send2(8'd3, 8'd5, 16'd14);
        send2(8'd0, 8'd0, 16'd7);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t3b_sum", b2.sum_ed, 8);
        check("t3b_sat", b2.sum_sat, 0);
        check("t3b_max", b2.max_ed, 7);
        b2.res_ready = 1'b1;
        @(posedge clk); #1;
        b2.res_ready = 1'b0;

        // Random windows against |a*b - p| summed, counted and maximised in plain integers.
        for (int w = 0; w < 25; w++) begin
            m_sum = 0; m_cnt = 0; m_max = 0;
            for (int k = 0; k < 4; k++) begin
                ra[k] = 8'($urandom);
                rb[k] = 8'($urandom);
                ex = longint'(ra[k]) * longint'(rb[k]);
                case ($urandom_range(0, 3))
                    0: rp[k] = 16'(ex);
                    1: rp[k] = 16'(ex + longint'($urandom_range(1, 300)));
                    2: rp[k] = 16'($urandom);
                    default: rp[k] = 16'(ex - longint'($urandom_range(0, 40)));
                endcase
                ed = (ex >= longint'(rp[k])) ? ex - longint'(rp[k]) : longint'(rp[k]) - ex;
                m_sum += ed;
                if (ed != 0) m_cnt++;
                if (ed > m_max) m_max = int'(ed);
            end
            start4();
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 2) == 0) begin @(posedge clk); #1; end
                send4(ra[k], rb[k], rp[k]);
            end
            wait_rep4();
            chk4("rand", (m_sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum, (m_sum > 64'hFFFF_FFFF) ? 1 : 0,
                 m_cnt, m_max);
            release4("rand", $urandom_range(0, 2), (m_sum > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_sum, m_cnt, m_max);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
